// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle CPU control sequencer with retire counter
module cpu_sequencer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        waitrequest,
    input  logic        data_read,
    input  logic        data_write,
    input  logic        write_enable,
    input  logic        halt_req,
    output logic        instr_read,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_load,
    output logic        pc_enable,
    output logic        reg_write_en,
    output logic        active,
    output logic [2:0]  state,
    output logic [31:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_HALT  = 3'd5
    } state_t;

    state_t      state_q;
    state_t      state_d;
    logic        rd_flag_q;
    logic        rd_flag_d;
    logic [31:0] count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            rd_flag_q <= 1'b0;
            count_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            rd_flag_q <= rd_flag_d;
            if (pc_enable) begin
                count_q <= count_q + 32'd1;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        rd_flag_d    = rd_flag_q;
        instr_read   = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        ir_load      = 1'b0;
        pc_enable    = 1'b0;
        reg_write_en = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                instr_read = 1'b1;
                if (!waitrequest) begin
                    ir_load = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (data_read || data_write) begin
                    // A simultaneous read and write is treated as a read
                    state_d   = S_MEM;
                    rd_flag_d = data_read;
                end else if (write_enable) begin
                    state_d = S_WB;
                end else begin
                    pc_enable = 1'b1;
                    state_d   = S_FETCH;
                end
            end
            S_MEM: begin
                // Request type comes from the flag so it cannot change mid-stall
                mem_read  = rd_flag_q;
                mem_write = !rd_flag_q;
                if (!waitrequest) begin
                    if (rd_flag_q) begin
                        state_d = S_WB;
                    end else begin
                        pc_enable = 1'b1;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_WB: begin
                reg_write_en = 1'b1;
                pc_enable    = 1'b1;
                state_d      = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    assign active      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign state       = state_q;
    assign instr_count = count_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

    logic        clk;
    logic        reset_n;
    logic        waitrequest;
    logic        data_read;
    logic        data_write;
    logic        write_enable;
    logic        halt_req;
    logic        instr_read;
    logic        mem_read;
    logic        mem_write;
    logic        ir_load;
    logic        pc_enable;
    logic        reg_write_en;
    logic        active;
    logic [2:0]  state;
    logic [31:0] instr_count;

    int checks;
    int errors;

    cpu_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .waitrequest  (waitrequest),
        .data_read    (data_read),
        .data_write   (data_write),
        .write_enable (write_enable),
        .halt_req     (halt_req),
        .instr_read   (instr_read),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .ir_load      (ir_load),
        .pc_enable    (pc_enable),
        .reg_write_en (reg_write_en),
        .active       (active),
        .state        (state),
        .instr_count  (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        waitrequest  = 1'b0;
        data_read    = 1'b0;
        data_write   = 1'b0;
        write_enable = 1'b0;
        halt_req     = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        cyc(); cyc();
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
        checks++; if (instr_read !== 1'b0) begin errors++; $display("FAIL reset_instr_read got %0b exp 0", instr_read); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL reset_active got %0b exp 0", active); end
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL reset_count got %0h exp 0", instr_count); end
        reset_n = 1'b1;
        #1;
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL post_reset_idle got %0d exp 0", state); end
        cyc();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL first_fetch_state got %0d exp 1", state); end
        checks++; if (instr_read !== 1'b1) begin errors++; $display("FAIL first_instr_read got %0b exp 1", instr_read); end
        checks++; if (active !== 1'b1) begin errors++; $display("FAIL fetch_active got %0b exp 1", active); end
    endtask

    task automatic test_alu();
        clear_inputs();
        write_enable = 1'b1;
        #1;
        checks++; if (ir_load !== 1'b1) begin errors++; $display("FAIL alu_ir_load got %0b exp 1", ir_load); end
        cyc();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL alu_exec_state got %0d exp 2", state); end
        checks++; if (pc_enable !== 1'b0) begin errors++; $display("FAIL alu_exec_pc_enable got %0b exp 0", pc_enable); end
        cyc();
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL alu_wb_state got %0d exp 4", state); end
        checks++; if ({reg_write_en, pc_enable} !== 2'b11) begin errors++; $display("FAIL alu_wb_strobes got %b exp 11", {reg_write_en, pc_enable}); end
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL alu_count_before got %0d exp 0", instr_count); end
        cyc();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL alu_back_fetch got %0d exp 1", state); end
        checks++; if (instr_count !== 32'd1) begin errors++; $display("FAIL alu_count_after got %0d exp 1", instr_count); end
    endtask

    task automatic test_branch();
        clear_inputs();
        cyc();
        checks++; if (pc_enable !== 1'b1) begin errors++; $display("FAIL branch_pc_enable got %0b exp 1", pc_enable); end
        checks++; if (reg_write_en !== 1'b0) begin errors++; $display("FAIL branch_reg_write got %0b exp 0", reg_write_en); end
        cyc();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL branch_fetch got %0d exp 1", state); end
        checks++; if (instr_count !== 32'd2) begin errors++; $display("FAIL branch_count got %0d exp 2", instr_count); end
    endtask

    task automatic test_load_stall();
        clear_inputs();
        data_read = 1'b1;
        cyc();
        cyc();
        checks++; if (state !== 3'd3) begin errors++; $display("FAIL load_mem_state got %0d exp 3", state); end
        data_read   = 1'b0;
        waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({mem_read, mem_write, pc_enable} !== 3'b100) begin errors++; $display("FAIL load_stall_%0d got %b exp 100", i, {mem_read, mem_write, pc_enable}); end
            cyc();
            checks++; if (state !== 3'd3) begin errors++; $display("FAIL load_stall_hold_%0d got %0d exp 3", i, state); end
        end
        waitrequest = 1'b0;
        #1;
        checks++; if ({mem_read, pc_enable} !== 2'b10) begin errors++; $display("FAIL load_accept got %b exp 10", {mem_read, pc_enable}); end
        cyc();
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL load_wb got %0d exp 4", state); end
        checks++; if (instr_count !== 32'd2) begin errors++; $display("FAIL load_count_wb got %0d exp 2", instr_count); end
        cyc();
        checks++; if (instr_count !== 32'd3) begin errors++; $display("FAIL load_count got %0d exp 3", instr_count); end
    endtask

    task automatic test_store();
        clear_inputs();
        data_write = 1'b1;
        cyc();
        cyc();
        data_write = 1'b0;
        #1;
        checks++; if ({mem_read, mem_write, pc_enable} !== 3'b011) begin errors++; $display("FAIL store_mem got %b exp 011", {mem_read, mem_write, pc_enable}); end
        cyc();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL store_fetch got %0d exp 1", state); end
        checks++; if (instr_count !== 32'd4) begin errors++; $display("FAIL store_count got %0d exp 4", instr_count); end
    endtask

    task automatic test_read_write_both();
        clear_inputs();
        data_read  = 1'b1;
        data_write = 1'b1;
        cyc();
        cyc();
        waitrequest = 1'b1;
        #1;
        checks++; if ({mem_read, mem_write} !== 2'b10) begin errors++; $display("FAIL rw_stall got %b exp 10", {mem_read, mem_write}); end
        cyc();
        waitrequest = 1'b0;
        #1;
        checks++; if ({mem_read, mem_write} !== 2'b10) begin errors++; $display("FAIL rw_accept got %b exp 10", {mem_read, mem_write}); end
        cyc();
        checks++; if (state !== 3'd4) begin errors++; $display("FAIL rw_wb got %0d exp 4", state); end
        clear_inputs();
        cyc();
        checks++; if (instr_count !== 32'd5) begin errors++; $display("FAIL rw_count got %0d exp 5", instr_count); end
    endtask

    task automatic test_wrap();
        clear_inputs();
        waitrequest = 1'b1;
        #1;
        checks++; if ({instr_read, ir_load} !== 2'b10) begin errors++; $display("FAIL fetch_stall got %b exp 10", {instr_read, ir_load}); end
        force dut.count_q = 32'hFFFF_FFFF;
        #1;
        release dut.count_q;
        cyc();
        checks++; if (state !== 3'd1) begin errors++; $display("FAIL fetch_stall_hold got %0d exp 1", state); end
        checks++; if (instr_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preset got %0h exp ffffffff", instr_count); end
        waitrequest = 1'b0;
        cyc();
        cyc();
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL wrap_count got %0h exp 0", instr_count); end
    endtask

    task automatic test_halt();
        clear_inputs();
        halt_req     = 1'b1;
        write_enable = 1'b1;
        cyc();
        checks++; if (pc_enable !== 1'b0) begin errors++; $display("FAIL halt_exec_pc_enable got %0b exp 0", pc_enable); end
        cyc();
        checks++; if (state !== 3'd5) begin errors++; $display("FAIL halt_state got %0d exp 5", state); end
        checks++; if (active !== 1'b0) begin errors++; $display("FAIL halt_active got %0b exp 0", active); end
        for (int i = 0; i < 20; i++) begin
            halt_req    = 1'b0;
            waitrequest = i[0];
            data_read   = i[1];
            data_write  = i[2];
            cyc();
            checks++; if (state !== 3'd5) begin errors++; $display("FAIL halt_hold_%0d got %0d exp 5", i, state); end
            checks++; if ({instr_read, mem_read, mem_write, ir_load, pc_enable, reg_write_en, active} !== 7'd0) begin errors++; $display("FAIL halt_strobes_%0d got %b exp 0", i, {instr_read, mem_read, mem_write, ir_load, pc_enable, reg_write_en, active}); end
        end
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL halt_count got %0d exp 0", instr_count); end
    endtask

    task automatic test_reset_in_stall();
        clear_inputs();
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();
        cyc();
        cyc();
        checks++; if (instr_count !== 32'd1) begin errors++; $display("FAIL rst_pre_count got %0d exp 1", instr_count); end
        waitrequest = 1'b1;
        #1;
        checks++; if (instr_read !== 1'b1) begin errors++; $display("FAIL rst_pre_instr_read got %0b exp 1", instr_read); end
        reset_n = 1'b0;
        #1;
        checks++; if (instr_read !== 1'b0) begin errors++; $display("FAIL rst_async_instr_read got %0b exp 0", instr_read); end
        checks++; if (state !== 3'd0) begin errors++; $display("FAIL rst_async_state got %0d exp 0", state); end
        checks++; if (instr_count !== 32'd0) begin errors++; $display("FAIL rst_async_count got %0d exp 0", instr_count); end
        reset_n = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_alu();
        test_branch();
        test_load_stall();
        test_store();
        test_read_write_both();
        test_wrap();
        test_halt();
        test_reset_in_stall();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
